pulse_transmitter_symbol_timer: RTL and testbench

Multi-symbol successor to the single-duration countdown timer. Holds a DEPTH-entry duration FIFO fed by a valid/ready handshake and plays the durations back-to-back with no idle cycles between symbols. Each symbol lasts exactly (duration+1) << prescaler cycles. Drives a toggling line level plus start/end strobes, and sits between the register interface and the pulse transmitter output pin.

---
 rtl/pulse_transmitter_duration_fifo.sv | 52 +++++
 rtl/pulse_transmitter_symbol_timer.sv | 152 +++++++++++++++
 tb/tb_pulse_transmitter_symbol_timer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_transmitter_duration_fifo.sv
// Register FIFO holding symbol durations; an entry is poppable only from the cycle after its write.
// flush empties the FIFO and takes priority over a same-cycle push.
module pulse_transmitter_duration_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             push_data,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == LVL_W'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && (level != '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end
endmodule

// File: rtl/pulse_transmitter_symbol_timer.sv
// Plays queued durations back-to-back; each symbol lasts (duration+1) << prescaler cycles.
// state | meaning:  IDLE | line at idle_level, waiting for en and data;  RUN | symbol in progress
module pulse_transmitter_symbol_timer #(
    parameter int   PRESCALER_WIDTH = 16,
    parameter int   TIMER_WIDTH     = 8,
    parameter int   DEPTH           = 4,
    localparam int  PSEL_W          = $clog2(PRESCALER_WIDTH)
) (
    input  logic                        clk,
    input  logic                        sys_rst_n,
    input  logic                        en,
    input  logic                        mode_repeat,
    input  logic [PSEL_W-1:0]           prescaler,
    input  logic                        idle_level,
    input  logic                        flush,
    input  logic                        in_valid,
    input  logic [TIMER_WIDTH-1:0]      in_duration,
    output logic                        in_ready,
    output logic [$clog2(DEPTH+1)-1:0]  level,
    output logic                        line_out,
    output logic                        symbol_start,
    output logic                        symbol_end,
    output logic                        busy,
    output logic                        underrun
);
    localparam int CNT_W = TIMER_WIDTH + 1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                     state, state_nx;
    logic [PRESCALER_WIDTH-1:0] tick_cnt;
    logic [CNT_W-1:0]           sym_cnt;
    logic [TIMER_WIDTH-1:0]     dur_lat;
    logic [PSEL_W-1:0]          psel_lat;
    logic [TIMER_WIDTH-1:0]     pop_data;
    logic                       full;
    logic                       have_data;
    logic                       last_cycle;
    logic                       pop;
    logic                       load_new;
    logic                       load_rep;
    logic                       set_underrun;

    // Down-counter reload value: tick period minus one.
    function automatic logic [PRESCALER_WIDTH-1:0] tick_len(input logic [PSEL_W-1:0] p);
        logic [PRESCALER_WIDTH-1:0] one;
        one = PRESCALER_WIDTH'(1);
        return (one << p) - one;
    endfunction

    pulse_transmitter_duration_fifo #(
        .WIDTH (TIMER_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (sys_rst_n),
        .push      (in_valid),
        .pop       (pop),
        .flush     (flush),
        .push_data (in_duration),
        .pop_data  (pop_data),
        .level     (level),
        .full      (full)
    );

    assign in_ready   = !full;
    assign have_data  = (level != '0);
    assign busy       = (state == RUN);
    assign last_cycle = busy && (tick_cnt == '0) && (sym_cnt == '0);
    assign symbol_end = last_cycle;

    always_comb begin
        state_nx     = state;
        pop          = 1'b0;
        load_new     = 1'b0;
        load_rep     = 1'b0;
        set_underrun = 1'b0;
        if (!en) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (have_data) begin
                        pop      = 1'b1;
                        load_new = 1'b1;
                        state_nx = RUN;
                    end
                end
                RUN: begin
                    if (last_cycle) begin
                        if (have_data) begin
                            pop      = 1'b1;
                            load_new = 1'b1;
                        end else if (mode_repeat) begin
                            load_rep = 1'b1;
                        end else begin
                            set_underrun = 1'b1;
                            state_nx     = IDLE;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            sym_cnt      <= '0;
            dur_lat      <= '0;
            psel_lat     <= '0;
            line_out     <= 1'b0;
            symbol_start <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            state        <= state_nx;
            symbol_start <= load_new || load_rep;
            if (!en) begin
                tick_cnt <= '0;
                sym_cnt  <= '0;
                line_out <= idle_level;
            end else if (load_new) begin
                dur_lat  <= pop_data;
                psel_lat <= prescaler;
                tick_cnt <= tick_len(prescaler);
                sym_cnt  <= CNT_W'(pop_data);
                line_out <= (state == IDLE) ? !idle_level : !line_out;
            end else if (load_rep) begin
                tick_cnt <= tick_len(psel_lat);
                sym_cnt  <= CNT_W'(dur_lat);
                line_out <= !line_out;
            end else if (state_nx == IDLE) begin
                tick_cnt <= '0;
                sym_cnt  <= '0;
                line_out <= idle_level;
            end else if (tick_cnt == '0) begin
                tick_cnt <= tick_len(psel_lat);
                sym_cnt  <= sym_cnt - CNT_W'(1);
            end else begin
                tick_cnt <= tick_cnt - PRESCALER_WIDTH'(1);
            end
            // Clearing wins over a same-cycle underrun event.
            if (!en || flush) begin
                underrun <= 1'b0;
            end else if (set_underrun) begin
                underrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pulse_transmitter_symbol_timer.sv
// Directed table/sequence checks plus randomized comparison against a cycle-count reference model.
module tb_pulse_transmitter_symbol_timer;
    localparam int D   = 4;
    localparam int PSW = 4;
    localparam int TW  = 8;

    logic           clk = 1'b0;
    logic           sys_rst_n = 1'b0;
    logic           en = 1'b0, mode_repeat = 1'b0, idle_level = 1'b0, flush = 1'b0, in_valid = 1'b0;
    logic [PSW-1:0] prescaler = '0;
    logic [TW-1:0]  in_duration = '0;
    logic           in_ready, line_out, symbol_start, symbol_end, busy, underrun;
    logic [2:0]     level;

    pulse_transmitter_symbol_timer #(.PRESCALER_WIDTH(16), .TIMER_WIDTH(TW), .DEPTH(D)) dut (
        .clk(clk), .sys_rst_n(sys_rst_n), .en(en), .mode_repeat(mode_repeat),
        .prescaler(prescaler), .idle_level(idle_level), .flush(flush),
        .in_valid(in_valid), .in_duration(in_duration), .in_ready(in_ready),
        .level(level), .line_out(line_out), .symbol_start(symbol_start),
        .symbol_end(symbol_end), .busy(busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: queue of durations plus remaining cycles of the current symbol.
    int  mq[$];
    bit  model_on = 1'b0;
    bit  m_run, m_line, m_start, m_ur;
    int  m_rem, m_dur, m_psel;

    task automatic model_reset();
        mq.delete();
        m_run = 0; m_line = 0; m_start = 0; m_ur = 0; m_rem = 0; m_dur = 0; m_psel = 0;
    endtask

    task automatic model_step();
        int  pre;
        bit  avail, endn;
        int  d;
        pre   = mq.size();
        avail = (pre > 0);
        endn  = m_run && (m_rem == 1);
        m_start = 0;
        if (!en) begin
            m_run = 0; m_rem = 0; m_line = idle_level; m_ur = 0;
        end else if (!m_run) begin
            if (avail) begin
                d = mq.pop_front();
                m_dur = d; m_psel = int'(prescaler); m_rem = (d + 1) << m_psel;
                m_run = 1; m_line = !idle_level; m_start = 1;
            end else begin
                m_line = idle_level;
            end
        end else if (endn) begin
            if (avail) begin
                d = mq.pop_front();
                m_dur = d; m_psel = int'(prescaler); m_rem = (d + 1) << m_psel;
                m_line = !m_line; m_start = 1;
            end else if (mode_repeat) begin
                m_rem = (m_dur + 1) << m_psel;
                m_line = !m_line; m_start = 1;
            end else begin
                m_run = 0; m_rem = 0; m_line = idle_level; m_ur = 1;
            end
        end else begin
            m_rem--;
        end
        if (flush) begin
            mq.delete();
            m_ur = 0;
        end else if (in_valid && pre < D) begin
            mq.push_back(int'(in_duration));
        end
    endtask

    task automatic model_compare();
        chk("rnd_line_out", line_out, m_line);
        chk("rnd_symbol_start", symbol_start, m_start);
        chk("rnd_symbol_end", symbol_end, (m_run && m_rem == 1));
        chk("rnd_busy", busy, m_run);
        chk("rnd_underrun", underrun, m_ur);
        chk("rnd_level", level, mq.size());
        chk("rnd_in_ready", in_ready, (mq.size() < D));
    endtask

    task automatic step();
        if (model_on) model_step();
        @(posedge clk);
        #1;
        if (model_on) model_compare();
    endtask

    task automatic do_reset();
        en = 0; mode_repeat = 0; idle_level = 0; flush = 0; in_valid = 0;
        prescaler = '0; in_duration = '0;
        @(negedge clk);
        sys_rst_n = 0;
        #12;
        @(negedge clk);
        sys_rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit vld; int dur;
        bit st; bit se; bit ln; bit bz; bit ur; int lvl;
    } vec_t;
    vec_t tv[8];

    int  starts[$];
    int  exp_starts[$];
    bit  seen;
    int  cnt;
    int  busy_cnt;

    initial begin
        tv[0] = '{1, 3, 0, 0, 0, 0, 0, 0};
        tv[1] = '{0, 0, 0, 0, 0, 0, 0, 1};
        tv[2] = '{0, 0, 1, 0, 1, 1, 0, 0};
        tv[3] = '{0, 0, 0, 0, 1, 1, 0, 0};
        tv[4] = '{0, 0, 0, 0, 1, 1, 0, 0};
        tv[5] = '{0, 0, 0, 1, 1, 1, 0, 0};
        tv[6] = '{0, 0, 0, 0, 0, 0, 1, 0};
        tv[7] = '{0, 0, 0, 0, 0, 0, 1, 0};

        // Reset state
        do_reset();
        chk("rst_line_out", line_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", level, 0);
        chk("rst_symbol_start", symbol_start, 0);
        chk("rst_symbol_end", symbol_end, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_in_ready", in_ready, 1);

        // Single duration 3, prescaler 0, table-driven per cycle
        en = 1;
        for (int c = 0; c < 8; c++) begin
            in_valid = tv[c].vld;
            in_duration = TW'(tv[c].dur);
            chk($sformatf("t1_start_c%0d", c), symbol_start, tv[c].st);
            chk($sformatf("t1_end_c%0d", c), symbol_end, tv[c].se);
            chk($sformatf("t1_line_c%0d", c), line_out, tv[c].ln);
            chk($sformatf("t1_busy_c%0d", c), busy, tv[c].bz);
            chk($sformatf("t1_underrun_c%0d", c), underrun, tv[c].ur);
            chk($sformatf("t1_level_c%0d", c), level, tv[c].lvl);
            step();
        end
        in_valid = 0;

        // Durations 1,2,0 at prescaler 1: starts at 2,6,12; final end at 13
        do_reset();
        en = 1; prescaler = 1;
        cnt = 0; busy_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            in_valid = (c < 3);
            in_duration = (c == 0) ? 8'd1 : (c == 1) ? 8'd2 : 8'd0;
            if (symbol_start) cnt++;
            if (busy) busy_cnt++;
            if (c == 2 || c == 6 || c == 12) chk($sformatf("t2_start_c%0d", c), symbol_start, 1);
            if (c == 2 || c == 12) chk($sformatf("t2_line_c%0d", c), line_out, 1);
            if (c == 6 || c == 14) chk($sformatf("t2_line_c%0d", c), line_out, 0);
            if (c == 5 || c == 11 || c == 13) chk($sformatf("t2_end_c%0d", c), symbol_end, 1);
            step();
        end
        in_valid = 0;
        chk("t2_start_count", cnt, 3);
        chk("t2_busy_cycles", busy_cnt, 12);

        // Overfill with en low, then play back exactly DEPTH symbols
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_duration = TW'(i + 1);
            if (i == 4) chk("t3_in_ready_full", in_ready, 0);
            step();
        end
        in_valid = 0;
        chk("t3_level_full", level, 4);
        en = 1; cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (symbol_start) cnt++;
            step();
        end
        chk("t3_symbols_played", cnt, 4);
        chk("t3_level_empty", level, 0);
        chk("t3_underrun", underrun, 1);

        // Repeat mode, duration 2 at prescaler 2; push 0 mid-symbol
        do_reset();
        mode_repeat = 1; prescaler = 2; en = 1;
        starts.delete(); cnt = 0;
        for (int c = 0; c < 60; c++) begin
            in_valid = (c == 0 || c == 43);
            in_duration = (c == 0) ? 8'd2 : 8'd0;
            if (symbol_start) starts.push_back(c);
            if (underrun) cnt++;
            step();
        end
        in_valid = 0;
        exp_starts = '{2, 14, 26, 38, 50, 54, 58};
        chk("t4_start_count", starts.size(), exp_starts.size());
        for (int i = 0; i < exp_starts.size(); i++) begin
            chk($sformatf("t4_start_%0d", i), (i < starts.size()) ? starts[i] : -1, exp_starts[i]);
        end
        chk("t4_underrun_cycles", cnt, 0);

        // en dropped mid-symbol, then resume
        do_reset();
        idle_level = 1; en = 1;
        for (int c = 0; c < 4; c++) begin
            in_valid = (c < 3); in_duration = 8'd5;
            step();
        end
        in_valid = 0;
        chk("t5_busy_before", busy, 1);
        en = 0;
        step();
        chk("t5_busy_drop", busy, 0);
        chk("t5_no_end", symbol_end, 0);
        chk("t5_line_idle", line_out, 1);
        chk("t5_level_kept", level, 2);
        chk("t5_underrun", underrun, 0);
        step();
        chk("t5_no_end_later", symbol_end, 0);
        en = 1;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            step();
            if (symbol_start) seen = 1;
        end
        chk("t5_resume_start", seen, 1);
        chk("t5_resume_level", level, 1);
        chk("t5_resume_line", line_out, 0);

        // Asynchronous reset mid-RUN with three entries left
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_duration = 8'd10;
            step();
        end
        in_valid = 0; en = 1;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            step();
            if (symbol_start) seen = 1;
        end
        chk("t6_started", seen, 1);
        chk("t6_level3", level, 3);
        step(); step();
        #2;
        sys_rst_n = 0;
        #1;
        chk("t6_line_zero", line_out, 0);
        chk("t6_start_zero", symbol_start, 0);
        chk("t6_end_zero", symbol_end, 0);
        chk("t6_busy_zero", busy, 0);
        chk("t6_underrun_zero", underrun, 0);
        chk("t6_level_zero", level, 0);
        en = 0;
        @(negedge clk);
        sys_rst_n = 1;
        step();
        chk("t6_level_after", level, 0);
        chk("t6_busy_after", busy, 0);

        // Randomized run against the reference model
        do_reset();
        model_reset();
        model_on = 1;
        for (int c = 0; c < 3000; c++) begin
            en          = (($urandom % 20) != 0);
            prescaler   = PSW'($urandom % 3);
            if (($urandom % 50) == 0) mode_repeat = !mode_repeat;
            if (($urandom % 100) == 0) idle_level = !idle_level;
            flush       = (($urandom % 64) == 0);
            in_valid    = $urandom % 2;
            in_duration = TW'($urandom % 6);
            step();
        end
        model_on = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
